// File: rtl/dcpu16_alu.sv
// dcpu16_alu -- execution stage of the DCPU-16 core.
//
// Captures operand a at phase 0 and operand b at phase 1, then executes
// the latched basic opcode at phase 3. Produces the registered write-back
// result, the overflow/extension register O and the condition flag CC.
// CC drops to 0 for exactly one instruction after a failed IFx so the
// control unit can suppress write-back of the skipped instruction.
//
// Ports:
//   clk  in   1   system clock, rising edge
//   rst  in   1   synchronous active-high reset (wins over ena)
//   ena  in   1   global clock enable; all state holds while low
//   pha  in   2   machine phase 0..3 from the control unit
//   opc  in   4   basic opcode, valid from phase 3
//   rda  in   DW  register-file read data, operand a
//   rdb  in   DW  register-file read data, operand b
//   CC   out  1   condition flag: 1 = execute/write, 0 = skip
//   res  out  DW  registered write-back result
//   ovf  out  DW  registered overflow register O
module dcpu16_alu #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [1:0]    pha,
    input  logic [3:0]    opc,
    input  logic [DW-1:0] rda,
    input  logic [DW-1:0] rdb,
    output logic          CC,
    output logic [DW-1:0] res,
    output logic [DW-1:0] ovf
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SKIP = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_ra;
    logic [15:0] r_rb;
    logic [15:0] r_res;
    logic [15:0] r_ovf;
    logic        r_cc;

    logic [16:0] w_add;
    logic [31:0] w_mul;
    logic        w_rb_zero;
    logic [15:0] w_divisor;
    logic [31:0] w_div;
    logic [15:0] w_mod;
    logic        w_big_shift;
    logic [31:0] w_shl;
    logic [31:0] w_shr;

    logic [15:0] w_res_next;
    logic [15:0] w_ovf_next;
    logic        w_if_op;
    logic        w_if_true;

    assign w_add     = {1'b0, r_ra} + {1'b0, r_rb};
    assign w_mul     = {16'h0000, r_ra} * {16'h0000, r_rb};
    assign w_rb_zero = (r_rb == 16'h0000);
    // Divide by 1 when rb is zero so no x/0 is ever evaluated; the
    // result is forced to zero below anyway.
    assign w_divisor = w_rb_zero ? 16'h0001 : r_rb;
    // (ra<<16)/rb: the upper half equals ra/rb, the lower half is the
    // fractional part that DIV leaves in O.
    assign w_div     = {r_ra, 16'h0000} / {16'h0000, w_divisor};
    assign w_mod     = r_ra % w_divisor;
    // Shift amounts of 32 or more clear both result and O.
    assign w_big_shift = |r_rb[15:5];
    assign w_shl     = {16'h0000, r_ra} << r_rb[4:0];
    assign w_shr     = {r_ra, 16'h0000} >> r_rb[4:0];

    always_comb begin
        w_res_next = r_res;
        w_ovf_next = r_ovf;
        w_if_op    = 1'b0;
        w_if_true  = 1'b0;
        case (opc)
            4'h0: w_res_next = r_ra;
            4'h1: w_res_next = r_rb;
            4'h2: begin
                w_res_next = w_add[15:0];
                w_ovf_next = w_add[16] ? 16'h0001 : 16'h0000;
            end
            4'h3: begin
                w_res_next = r_ra - r_rb;
                w_ovf_next = (r_ra < r_rb) ? 16'hFFFF : 16'h0000;
            end
            4'h4: begin
                w_res_next = w_mul[15:0];
                w_ovf_next = w_mul[31:16];
            end
            4'h5: begin
                w_res_next = w_rb_zero ? 16'h0000 : w_div[31:16];
                w_ovf_next = w_rb_zero ? 16'h0000 : w_div[15:0];
            end
            4'h6: w_res_next = w_rb_zero ? 16'h0000 : w_mod;
            4'h7: begin
                w_res_next = w_big_shift ? 16'h0000 : w_shl[15:0];
                w_ovf_next = w_big_shift ? 16'h0000 : w_shl[31:16];
            end
            4'h8: begin
                w_res_next = w_big_shift ? 16'h0000 : w_shr[31:16];
                w_ovf_next = w_big_shift ? 16'h0000 : w_shr[15:0];
            end
            4'h9: w_res_next = r_ra & r_rb;
            4'hA: w_res_next = r_ra | r_rb;
            4'hB: w_res_next = r_ra ^ r_rb;
            4'hC: begin
                w_if_op   = 1'b1;
                w_if_true = (r_ra == r_rb);
            end
            4'hD: begin
                w_if_op   = 1'b1;
                w_if_true = (r_ra != r_rb);
            end
            4'hE: begin
                w_if_op   = 1'b1;
                w_if_true = (r_ra > r_rb);
            end
            default: begin
                w_if_op   = 1'b1;
                w_if_true = ((r_ra & r_rb) != 16'h0000);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_ra    <= 16'h0000;
            r_rb    <= 16'h0000;
            r_res   <= 16'h0000;
            r_ovf   <= 16'h0000;
            r_cc    <= 1'b1;
        end else if (ena) begin
            case (pha)
                2'd0: r_ra <= rda;
                2'd1: r_rb <= rdb;
                2'd2: ;
                default: begin
                    // The skipped instruction still produces res, but O
                    // must not be disturbed by it.
                    r_res <= w_res_next;
                    if (r_state == ST_RUN) begin
                        r_ovf <= w_ovf_next;
                    end
                    // A failed IFx skips one instruction; SKIP always
                    // returns to RUN, so IFx chains never extend a skip.
                    if ((r_state == ST_RUN) && w_if_op && !w_if_true) begin
                        r_state <= ST_SKIP;
                        r_cc    <= 1'b0;
                    end else begin
                        r_state <= ST_RUN;
                        r_cc    <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign CC  = r_cc;
    assign res = r_res;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_dcpu16_alu.sv
// Directed testbench for dcpu16_alu. The bench plays the control unit,
// stepping pha through 0..3 per instruction, and checks res/ovf/CC one
// step after each phase-3 edge against hand-computed values.
module tb_dcpu16_alu;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [1:0]  pha;
    logic [3:0]  opc;
    logic [15:0] rda;
    logic [15:0] rdb;
    logic        CC;
    logic [15:0] res;
    logic [15:0] ovf;

    int n_checks;
    int n_pass;

    dcpu16_alu #(.DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .pha (pha),
        .opc (opc),
        .rda (rda),
        .rdb (rdb),
        .CC  (CC),
        .res (res),
        .ovf (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_res,
                             input logic [15:0] e_ovf, input logic e_cc);
        check({tag, ".res"}, res, e_res);
        check({tag, ".ovf"}, ovf, e_ovf);
        check({tag, ".cc"}, {15'h0, CC}, {15'h0, e_cc});
    endtask

    // One step: present inputs, take one rising edge, settle 1 time unit.
    task automatic step(input logic [1:0] p, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b);
        pha = p;
        opc = op;
        rda = a;
        rdb = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input string tag, input logic [3:0] op,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] e_res, input logic [15:0] e_ovf,
                            input logic e_cc);
        for (int p = 0; p < 4; p++) begin
            step(p[1:0], op, a, b);
        end
        $display("instr %-8s opc=%h a=%04h b=%04h -> res=%04h ovf=%04h cc=%0b",
                 tag, op, a, b, res, ovf, CC);
        check_out(tag, e_res, e_ovf, e_cc);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        ena = 1'b1;
        pha = 2'd0;
        opc = 4'h0;
        rda = 16'h0000;
        rdb = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        $display("reset   -> res=%04h ovf=%04h cc=%0b", res, ovf, CC);
        check_out("reset", 16'h0000, 16'h0000, 1'b1);
        rst = 1'b0;

        // Arithmetic and boundary cases
        do_instr("add_c",   4'h2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1'b1);
        do_instr("sub_b",   4'h3, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b1);
        do_instr("mul",     4'h4, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1);
        do_instr("div0",    4'h5, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        do_instr("shl",     4'h7, 16'h8001, 16'h0001, 16'h0002, 16'h0001, 1'b1);
        do_instr("shr",     4'h8, 16'h0003, 16'h0001, 16'h0001, 16'h8000, 1'b1);
        do_instr("and",     4'h9, 16'hF0F0, 16'hFF00, 16'hF000, 16'h8000, 1'b1);
        do_instr("mod0",    4'h6, 16'h0007, 16'h0000, 16'h0000, 16'h8000, 1'b1);
        do_instr("div",     4'h5, 16'h0007, 16'h0002, 16'h0003, 16'h8000, 1'b1);
        do_instr("shl32",   4'h7, 16'h0001, 16'h0020, 16'h0000, 16'h0000, 1'b1);
        do_instr("add_c2",  4'h2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1'b1);

        // Skip behaviour
        do_instr("ife_f",   4'hC, 16'h0005, 16'h0006, 16'h0000, 16'h0001, 1'b0);
        do_instr("sub_skp", 4'h3, 16'h0000, 16'h0001, 16'hFFFF, 16'h0001, 1'b1);
        do_instr("add",     4'h2, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b1);
        do_instr("ife_f2",  4'hC, 16'h0005, 16'h0006, 16'h0003, 16'h0000, 1'b0);
        do_instr("ifn_skp", 4'hD, 16'h0004, 16'h0004, 16'h0003, 16'h0000, 1'b1);
        do_instr("ifg_t",   4'hE, 16'h0005, 16'h0003, 16'h0003, 16'h0000, 1'b1);
        do_instr("ifb_f",   4'hF, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b0);
        do_instr("add_skp", 4'h2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1);
        do_instr("nonbas",  4'h0, 16'hBEEF, 16'h1111, 16'hBEEF, 16'h0000, 1'b1);
        do_instr("bor",     4'hA, 16'hF000, 16'h000F, 16'hF00F, 16'h0000, 1'b1);
        do_instr("ifn_t",   4'hD, 16'h0001, 16'h0002, 16'hF00F, 16'h0000, 1'b1);
        do_instr("xor",     4'hB, 16'hFF00, 16'h0FF0, 16'hF0F0, 16'h0000, 1'b1);

        // Clock-enable hold mid-instruction
        step(2'd0, 4'h4, 16'h1003, 16'h0000);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(2'd1, 4'h1, 16'hDEAD, 16'hDEAD);
        end
        for (int i = 0; i < 2; i++) begin
            step(2'd3, 4'h1, 16'hDEAD, 16'hDEAD);
        end
        $display("hold    -> res=%04h ovf=%04h cc=%0b", res, ovf, CC);
        check_out("hold", 16'hF0F0, 16'h0000, 1'b1);
        ena = 1'b1;
        step(2'd1, 4'h4, 16'hDEAD, 16'h0105);
        step(2'd2, 4'h4, 16'hDEAD, 16'h0105);
        step(2'd3, 4'h4, 16'hDEAD, 16'h0105);
        $display("resume  -> res=%04h ovf=%04h cc=%0b", res, ovf, CC);
        check_out("resume", 16'h530F, 16'h0010, 1'b1);
        do_instr("mul_ref", 4'h4, 16'h1003, 16'h0105, 16'h530F, 16'h0010, 1'b1);

        // Reset while in SKIP, mid-instruction
        do_instr("sub_b2",  4'h3, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b1);
        do_instr("ife_f3",  4'hC, 16'h0005, 16'h0006, 16'hFFFF, 16'hFFFF, 1'b0);
        step(2'd0, 4'h2, 16'h0001, 16'h0001);
        step(2'd1, 4'h2, 16'h0001, 16'h0001);
        rst = 1'b1;
        step(2'd2, 4'h2, 16'h0001, 16'h0001);
        rst = 1'b0;
        $display("rst_mid -> res=%04h ovf=%04h cc=%0b", res, ovf, CC);
        check_out("rst_mid", 16'h0000, 16'h0000, 1'b1);
        do_instr("post_rst", 4'h4, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcpu16_alu.md
Name: dcpu16_alu

Overview:
- Execution stage directly downstream of the instruction control unit.
- Consumes the control unit's phase counter (pha) and latched basic opcode (opc), plus register-file read data.
- Produces the 16-bit write-back result, the overflow register O, and the condition flag CC.
- CC feeds back into the control unit to gate register write enable and implement IFx skip.

Parameters:
- DW, 16, datapath width; only 16 is supported.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  global clock enable; when low, all state holds
- pha  in  2  machine phase from control unit, free-running 0,1,2,3
- opc  in  4  basic opcode; valid from phase 3 onward
- rda  in  16  register-file read data for operand a
- rdb  in  16  register-file read data for operand b
- CC  out  1  condition flag; 1 = execute/write allowed, 0 = skip
- res  out  16  write-back result, registered
- ovf  out  16  overflow/extension register O, registered

Behaviour:
- Reset (rst=1 at clk edge, takes priority over ena): res=0, ovf=0, CC=1, internal operand registers ra=0, rb=0, skip state cleared.
- ena=0: every register holds, including mid-instruction; resuming continues at the same phase.
- Operand capture:
  - pha=0: ra <= rda.
  - pha=1: rb <= rdb.
  - pha=2: no datapath update.
- Execute at pha=3, using latched ra, rb and current opc. Products are 32-bit intermediates; res takes the low 16 bits.
  - 0 (non-basic): res <= ra; ovf and CC hold.
  - 1 SET: res <= rb.
  - 2 ADD: res <= ra+rb; ovf <= 0x0001 on carry out of bit 15, else 0.
  - 3 SUB: res <= ra-rb; ovf <= 0xFFFF on borrow, else 0.
  - 4 MUL: res <= low16(ra*rb); ovf <= high16(ra*rb).
  - 5 DIV: res <= ra/rb; ovf <= low16((ra<<16)/rb). If rb=0, res=0 and ovf=0.
  - 6 MOD: res <= ra%rb; rb=0 gives res=0; ovf holds.
  - 7 SHL: res <= low16(ra<<rb); ovf <= high16(ra<<rb). rb>=32 gives both 0.
  - 8 SHR: res <= ra>>rb; ovf <= low16((ra<<16)>>rb). rb>=32 gives both 0.
  - 9 AND, A BOR, B XOR: bitwise ops into res; ovf holds.
  - C IFE (ra==rb), D IFN (ra!=rb), E IFG (ra>rb, unsigned), F IFB ((ra&rb)!=0): res holds; ovf holds.
- Skip state machine (states RUN, SKIP), updated only at pha=3 with ena=1:
  - RUN with an IFx opcode whose condition is false -> SKIP, CC <= 0.
  - RUN with any other opcode, or a true IFx -> RUN, CC <= 1.
  - SKIP -> RUN, CC <= 1, regardless of opcode. The skipped instruction's ALU results are still computed, but ovf is NOT updated while in SKIP.
- CC is stable from the pha=3 edge through the following pha=0 edge, where the control unit samples it.
- An IFx following a failed IFx is itself skipped. It cannot chain a further skip: SKIP always returns to RUN.
- Latency: operands become visible 1 cycle after capture; res/ovf/CC are valid 1 cycle after the pha=3 edge and hold for 3 cycles.
- rst asserted mid-instruction aborts it. Phase 0 resumes in step with the control unit, which resets its own pha to 0 on the same edge.

Test Plan:
- Reset, then 4 phases with opc=2, rda=0xFFFF, rdb=0x0001 -> res=0x0000, ovf=0x0001, CC=1.
- opc=3, rda=0x0000, rdb=0x0001 -> res=0xFFFF, ovf=0xFFFF; then opc=4, rda=0x1234, rdb=0x0100 -> res=0x3400, ovf=0x0012.
- opc=5, rda=0x0007, rdb=0 -> res=0, ovf=0; opc=7, rda=0x8001, rdb=1 -> res=0x0002, ovf=0x0001; opc=8, rda=0x0003, rdb=1 -> res=0x0001, ovf=0x8000.
- opc=C with rda=5, rdb=6 -> CC=0. Next instruction opc=2 -> ovf unchanged, and CC returns to 1 after its pha=3. Third instruction proceeds normally.
- Hold ena=0 for 5 cycles at pha=1 mid-instruction -> no register change; after re-enable, result equals the uninterrupted run.
- Assert rst during pha=2 while in SKIP -> res=0, ovf=0, CC=1 on the next cycle.
